// File: rtl/hazard_stall_unit_if.sv
// Decode-to-ID/EX control bundle for hazard_stall_unit: raw decode controls and
// hazard sources in, gated controls, pipeline strobes and perf counters out.
interface hazard_stall_unit_if #(
  parameter int unsigned REG_ADDR_W = 3,
  parameter int unsigned JSEL_W     = 2
);
  localparam int unsigned PERF_W = 16;

  logic                  reg_cntrl;
  logic                  RAM_cntrl;
  logic                  MemtoReg_cntrl;
  logic [JSEL_W-1:0]     jsel_cntrl;
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic                  id_rs_used;
  logic                  id_rt_used;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_mem_read;
  logic                  branch_taken;

  logic                  reg_write_en_out;
  logic                  RAM_writeEnable_out;
  logic                  MemtoReg_out;
  logic [JSEL_W-1:0]     jsel_out;
  logic                  pc_write_en;
  logic                  ifid_write_en;
  logic                  ifid_flush;
  logic                  bubble;
  logic [PERF_W-1:0]     stall_cycles;
  logic [PERF_W-1:0]     flush_cycles;

  modport master (
    output reg_cntrl, RAM_cntrl, MemtoReg_cntrl, jsel_cntrl,
    output id_rs, id_rt, id_rs_used, id_rt_used, ex_rd, ex_mem_read, branch_taken,
    input  reg_write_en_out, RAM_writeEnable_out, MemtoReg_out, jsel_out,
    input  pc_write_en, ifid_write_en, ifid_flush, bubble,
    input  stall_cycles, flush_cycles
  );

  modport slave (
    input  reg_cntrl, RAM_cntrl, MemtoReg_cntrl, jsel_cntrl,
    input  id_rs, id_rt, id_rs_used, id_rt_used, ex_rd, ex_mem_read, branch_taken,
    output reg_write_en_out, RAM_writeEnable_out, MemtoReg_out, jsel_out,
    output pc_write_en, ifid_write_en, ifid_flush, bubble,
    output stall_cycles, flush_cycles
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// Load-use / taken-branch hazard unit: inserts bubbles between decode and ID/EX.
// Optional HAZARD_PERF_CNT_EN builds saturating stall/flush cycle counters.
module hazard_stall_unit #(
  parameter int unsigned REG_ADDR_W        = 3,
  parameter int unsigned JSEL_W            = 2,
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned FLUSH_CYCLES      = 1
) (
  input logic             clk,
  input logic             rst,
  hazard_stall_unit_if.slave bus
);
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned PERF_W = 16;

  localparam bit STALL_MULTI = (LOAD_STALL_CYCLES > 1);
  localparam bit FLUSH_MULTI = (FLUSH_CYCLES > 1);
  localparam logic [CNT_W-1:0] STALL_RELOAD =
    CNT_W'(STALL_MULTI ? LOAD_STALL_CYCLES - 2 : 0);
  localparam logic [CNT_W-1:0] FLUSH_RELOAD =
    CNT_W'(FLUSH_MULTI ? FLUSH_CYCLES - 2 : 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;

  logic [REG_ADDR_W-1:0] w_rs;
  logic [REG_ADDR_W-1:0] w_rt;
  logic [REG_ADDR_W-1:0] w_rd;
  logic [JSEL_W-1:0]     w_jsel;
  logic                  w_rs_hit;
  logic                  w_rt_hit;
  logic                  w_load_use;
  logic                  w_bubble;
  logic                  w_pc_we;
  logic                  w_ifid_we;
  logic                  w_flush;

  assign w_rs   = bus.id_rs;
  assign w_rt   = bus.id_rt;
  assign w_rd   = bus.ex_rd;
  assign w_jsel = bus.jsel_cntrl;

  // Register 0 is hard-wired, so a load targeting it never creates a hazard.
  assign w_rs_hit   = bus.id_rs_used && (w_rs == w_rd);
  assign w_rt_hit   = bus.id_rt_used && (w_rt == w_rd);
  assign w_load_use = bus.ex_mem_read && (w_rd != '0) && (w_rs_hit || w_rt_hit);

  // A branch (or an ongoing flush) wins over any stall source.
  always_comb begin
    w_bubble  = 1'b0;
    w_pc_we   = 1'b1;
    w_ifid_we = 1'b1;
    w_flush   = 1'b0;
    if (bus.branch_taken || (r_state == ST_FLUSH)) begin
      w_bubble = 1'b1;
      w_flush  = 1'b1;
    end else if ((r_state == ST_STALL) || w_load_use) begin
      w_bubble  = 1'b1;
      w_pc_we   = 1'b0;
      w_ifid_we = 1'b0;
    end
  end

  // cnt holds the bubbles still owed after the current one, minus one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.branch_taken) begin
            if (FLUSH_MULTI) begin
              r_state <= ST_FLUSH;
              r_cnt   <= FLUSH_RELOAD;
            end
          end else if (w_load_use && STALL_MULTI) begin
            r_state <= ST_STALL;
            r_cnt   <= STALL_RELOAD;
          end
        end
        ST_STALL: begin
          if (bus.branch_taken) begin
            r_state <= FLUSH_MULTI ? ST_FLUSH : ST_IDLE;
            r_cnt   <= FLUSH_RELOAD;
          end else if (r_cnt == '0) begin
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_FLUSH: begin
          if (bus.branch_taken) begin
            r_state <= FLUSH_MULTI ? ST_FLUSH : ST_IDLE;
            r_cnt   <= FLUSH_RELOAD;
          end else if (r_cnt == '0) begin
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.bubble              = w_bubble;
  assign bus.pc_write_en         = w_pc_we;
  assign bus.ifid_write_en       = w_ifid_we;
  assign bus.ifid_flush          = w_flush;
  assign bus.reg_write_en_out    = bus.reg_cntrl      && !w_bubble;
  assign bus.RAM_writeEnable_out = bus.RAM_cntrl      && !w_bubble;
  assign bus.MemtoReg_out        = bus.MemtoReg_cntrl && !w_bubble;
  assign bus.jsel_out            = w_bubble ? '0 : w_jsel;

`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_W-1:0] r_stall_cycles;
  logic [PERF_W-1:0] r_flush_cycles;

  // Saturating counters of frozen-PC and IF/ID-flush cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles <= '0;
      r_flush_cycles <= '0;
    end else begin
      if (!w_pc_we && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + PERF_W'(1);
      end
      if (w_flush && (r_flush_cycles != '1)) begin
        r_flush_cycles <= r_flush_cycles + PERF_W'(1);
      end
    end
  end

  assign bus.stall_cycles = r_stall_cycles;
  assign bus.flush_cycles = r_flush_cycles;
`else
  assign bus.stall_cycles = PERF_W'(0);
  assign bus.flush_cycles = PERF_W'(0);
`endif
endmodule
